// File: rtl/hit_judge_if.sv
// Game-side signal bundle between the hit_judge core and the board: round start,
// lit-LED pattern and buttons in; score, lives and round status out.
interface hit_judge_if #(
  parameter int SCORE_W = 8
);
  logic               freq;
  logic [7:0]         LED_num;
  logic [7:0]         btn;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               hit;
  logic               miss;
  logic               armed;
  logic               game_over;

  modport master (
    output freq, LED_num, btn,
    input  score, lives, hit, miss, armed, game_over
  );

  modport slave (
    input  freq, LED_num, btn,
    output score, lives, hit, miss, armed, game_over
  );
endinterface

// File: rtl/hit_judge.sv
// Whack-an-LED judge: arms a timed round per freq pulse and scores button presses.
// Press edge -> hit/miss pulse one clk later; no backpressure, inputs are sampled every cycle.
module hit_judge #(
  parameter int WINDOW_CYCLES = 100000000,
  parameter int CNT_W         = 27,
  parameter int SCORE_W       = 8,
  parameter int LIVES         = 3
) (
  input logic        clk,
  input logic        rst,
  hit_judge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [7:0]         target;
  logic [7:0]         target_n;
  logic [7:0]         btn_q;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] score_n;
  logic [1:0]         lives;
  logic [1:0]         lives_n;
  logic               hit;
  logic               hit_n;
  logic               miss;
  logic               miss_n;

  logic [7:0]         press;
  logic               led_onehot;
  logic [1:0]         lives_dec;
  state_t             after_round;

  assign press      = bus.btn & ~btn_q;
  assign led_onehot = (bus.LED_num != 8'd0) &&
                      ((bus.LED_num & (bus.LED_num - 8'd1)) == 8'd0);
  assign lives_dec  = lives - 2'd1;
  // A freq arriving on the judging cycle chains straight into the next round.
  assign after_round = bus.freq ? LOAD : IDLE;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    target_n = target;
    score_n  = score;
    lives_n  = lives;
    hit_n    = 1'b0;
    miss_n   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.freq) begin
          state_n = LOAD;
        end
      end

      LOAD: begin
        if (led_onehot) begin
          target_n = bus.LED_num;
          cnt_n    = '0;
          state_n  = ARMED;
        end else begin
          state_n = IDLE;
        end
      end

      ARMED: begin
        if (press != 8'd0) begin
          if (press == target) begin
            hit_n   = 1'b1;
            score_n = (score == {SCORE_W{1'b1}}) ? score : score + SCORE_W'(1);
            state_n = after_round;
          end else begin
            miss_n  = 1'b1;
            lives_n = lives_dec;
            state_n = (lives_dec == 2'd0) ? OVER : after_round;
          end
        end else if (bus.freq) begin
          cnt_n   = '0;
          state_n = LOAD;
        end else if (cnt == CNT_LAST) begin
          miss_n  = 1'b1;
          lives_n = lives_dec;
          state_n = (lives_dec == 2'd0) ? OVER : IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      OVER: begin
        state_n = OVER;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= 8'd0;
      btn_q  <= 8'hFF;
      score  <= '0;
      lives  <= LIVES_INIT;
      hit    <= 1'b0;
      miss   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      target <= target_n;
      btn_q  <= bus.btn;
      score  <= score_n;
      lives  <= lives_n;
      hit    <= hit_n;
      miss   <= miss_n;
    end
  end

  assign bus.score     = score;
  assign bus.lives     = lives;
  assign bus.hit       = hit;
  assign bus.miss      = miss;
  assign bus.armed     = (state == ARMED);
  assign bus.game_over = (state == OVER);

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with a 16-cycle window and 3 lives.
module tb_hit_judge;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hit_judge_if #(.SCORE_W(8)) bus ();

  hit_judge #(
    .WINDOW_CYCLES(16),
    .CNT_W        (5),
    .SCORE_W      (8),
    .LIVES        (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {hit, miss, armed, game_over, lives[1:0], score[7:0]}.
  function automatic logic [13:0] outs();
    return {bus.hit, bus.miss, bus.armed, bus.game_over, bus.lives, bus.score};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [7:0] led);
    bus.freq    = 1'b1;
    bus.LED_num = 8'h00;
    tick();
    bus.freq    = 1'b0;
    bus.LED_num = led;
    tick();
  endtask

  task automatic test_reset();
    logic [13:0] o;
    rst = 1'b1; bus.freq = 1'b0; bus.LED_num = 8'h00; bus.btn = 8'h01;
    tick(); tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00}) begin
      bad++; $display("FAIL reset_values got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00});
    end
    rst = 1'b0;
    tick(); tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00}) begin
      bad++; $display("FAIL held_through_reset got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00});
    end
    bus.btn = 8'h00; tick();
    bus.btn = 8'h01; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00}) begin
      bad++; $display("FAIL idle_press_ignored got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00});
    end
    bus.btn = 8'h00; tick();
  endtask

  task automatic test_hit();
    logic [13:0] o;
    arm(8'h04);
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'h00}) begin
      bad++; $display("FAIL armed_rise got %h want %h", o, {1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'h00});
    end
    for (int i = 0; i < 4; i++) tick();
    bus.btn = 8'h04; tick();
    o = outs(); total++;
    if (o !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h01}) begin
      bad++; $display("FAIL hit_pulse got %h want %h", o, {1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h01});
    end
    bus.btn = 8'h00; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h01}) begin
      bad++; $display("FAIL hit_one_cycle got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h01});
    end
  endtask

  task automatic test_miss();
    logic [13:0] o;
    arm(8'h10);
    bus.btn = 8'h08; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'h01}) begin
      bad++; $display("FAIL wrong_button got %h want %h", o, {1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'h01});
    end
    bus.btn = 8'h00; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'h01}) begin
      bad++; $display("FAIL miss_one_cycle got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'h01});
    end
    arm(8'h10);
    bus.btn = 8'h30; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'h01}) begin
      bad++; $display("FAIL target_plus_extra got %h want %h", o, {1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'h01});
    end
    bus.btn = 8'h00; tick();
  endtask

  task automatic test_timeout();
    logic [13:0] o;
    arm(8'h80);
    for (int i = 0; i < 15; i++) begin
      tick();
      o = outs(); total++;
      if (o !== {1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'h01}) begin
        bad++; $display("FAIL window_open[%0d] got %h want %h", i, o, {1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'h01});
      end
    end
    tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h01}) begin
      bad++; $display("FAIL timeout_game_over got %h want %h", o, {1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h01});
    end
    bus.freq = 1'b1; tick();
    bus.freq = 1'b0; bus.LED_num = 8'h01; bus.btn = 8'h01; tick();
    bus.btn = 8'h00; tick();
    bus.btn = 8'h01; bus.freq = 1'b1; tick();
    bus.btn = 8'h00; bus.freq = 1'b0; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h01}) begin
      bad++; $display("FAIL over_frozen got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h01});
    end
  endtask

  task automatic test_freq_press();
    logic [13:0] o;
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00}) begin
      bad++; $display("FAIL reset_exits_over got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00});
    end
    arm(8'h02);
    bus.freq = 1'b1; bus.btn = 8'h02; tick();
    o = outs(); total++;
    if (o !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h01}) begin
      bad++; $display("FAIL freq_with_hit got %h want %h", o, {1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h01});
    end
    bus.freq = 1'b0; bus.LED_num = 8'h08; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'h01}) begin
      bad++; $display("FAIL chained_rearm got %h want %h", o, {1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'h01});
    end
    bus.btn = 8'h0A; tick();
    o = outs(); total++;
    if (o !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h02}) begin
      bad++; $display("FAIL new_target_hit got %h want %h", o, {1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h02});
    end
    bus.btn = 8'h00; tick();
  endtask

  task automatic test_saturate();
    logic [13:0] o;
    for (int r = 0; r < 253; r++) begin
      arm(8'h01);
      bus.btn = 8'h01; tick();
      bus.btn = 8'h00; tick();
    end
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF}) begin
      bad++; $display("FAIL score_reaches_ff got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF});
    end
    arm(8'h01);
    bus.btn = 8'h01; tick();
    o = outs(); total++;
    if (o !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF}) begin
      bad++; $display("FAIL score_saturates got %h want %h", o, {1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF});
    end
    bus.btn = 8'h00; tick();
  endtask

  task automatic test_invalid_and_abort();
    logic [13:0] o;
    arm(8'h00);
    tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF}) begin
      bad++; $display("FAIL zero_pattern got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF});
    end
    arm(8'h03);
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF}) begin
      bad++; $display("FAIL multi_hot_pattern got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF});
    end
    arm(8'h04);
    for (int i = 0; i < 10; i++) tick();
    bus.freq = 1'b1; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF}) begin
      bad++; $display("FAIL abandon_no_miss got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF});
    end
    bus.freq = 1'b0; bus.LED_num = 8'h04; tick();
    for (int i = 0; i < 15; i++) tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'hFF}) begin
      bad++; $display("FAIL counter_restart got %h want %h", o, {1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'hFF});
    end
    tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'hFF}) begin
      bad++; $display("FAIL restarted_timeout got %h want %h", o, {1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'hFF});
    end
    arm(8'h04);
    tick(); tick();
    rst = 1'b1; bus.btn = 8'h04; tick();
    o = outs(); total++;
    if (o !== {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00}) begin
      bad++; $display("FAIL reset_mid_round got %h want %h", o, {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00});
    end
    rst = 1'b0; bus.btn = 8'h00; tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.freq    = 1'b0;
    bus.LED_num = 8'h00;
    bus.btn     = 8'h00;
    test_reset();
    test_hit();
    test_miss();
    test_timeout();
    test_freq_press();
    test_saturate();
    test_invalid_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Player-side counterpart to the LED randomizer in the whack-an-LED game.
- Each freq pulse starts a round. The block captures the one-hot LED pattern the randomizer just lit, then watches the board buttons for a press within a timed window.
- Judges hit, wrong-button or timeout, keeps score and remaining lives, and freezes in game-over when lives run out.

Parameters:
- WINDOW_CYCLES, 100000000, clk cycles a round stays armed (1 s at 100 MHz); must be >= 2.
- CNT_W, 27, width of window counter; must hold WINDOW_CYCLES-1.
- SCORE_W, 8, score width.
- LIVES, 3, lives at reset; range 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- freq  in  1  one-cycle round-start pulse from the frequency module
- LED_num  in  8  one-hot lit-LED pattern from the randomizer; updates on the clk edge where freq=1
- btn  in  8  player buttons, already synchronized and debounced, level, bit i pairs with LED i
- score  out  SCORE_W  hits so far, saturating
- lives  out  2  remaining lives
- hit  out  1  one-cycle pulse on a correct press
- miss  out  1  one-cycle pulse on a wrong press or timeout
- armed  out  1  high while a round is awaiting a press
- game_over  out  1  level, high once lives reach 0

Behaviour:
- Reset is synchronous and active-high. All state updates happen on posedge clk; rst has priority over everything else.
- Reset values: score=0, lives=LIVES, hit=0, miss=0, armed=0, game_over=0, state=IDLE, window counter=0, target=0, btn_q=8'hFF.
- btn_q=8'hFF at reset means a button held through reset never registers as a press.

Press detection:
- press = btn & ~btn_q; btn_q <= btn every cycle in every state.
- Only rising edges count. A held button counts once.

States:
- IDLE: armed=0.
  - freq=1 -> LOAD.
  - Presses are ignored.
- LOAD: one cycle, armed=0. LED_num is sampled here, one cycle after freq, because the randomizer updates it on the freq edge.
  - If LED_num has exactly one bit set: target <= LED_num, counter <= 0 -> ARMED.
  - Otherwise (zero, multi-hot or X-resolved): no judgement -> IDLE.
  - Presses are ignored.
- ARMED: armed=1. Counter increments each cycle. Evaluation priority, first match wins:
  1. press != 0 and press == target: hit=1; score+1, saturating at all-ones -> IDLE.
  2. press != 0 and press != target (any wrong bit, including target plus an extra bit in the same cycle): miss=1, lives-1.
  3. No press and counter == WINDOW_CYCLES-1: timeout; miss=1, lives-1.
  - After a miss: if the new lives value is 0, go to OVER and set game_over=1; otherwise go to IDLE.
- OVER: armed=0, game_over=1.
  - score and lives are frozen; freq and btn are ignored.
  - Only rst exits.

Timing and pulses:
- hit and miss are registered, asserted for exactly one cycle on the edge that leaves ARMED, and mutually exclusive.
- Latency: press rising edge seen at btn -> hit/miss high on the next clk edge.

Simultaneous events:
- freq in ARMED with no press that cycle: the round is abandoned without a miss -> LOAD, and the counter restarts.
- freq in ARMED with a press the same cycle: the press is judged against the old target (score/lives/pulse update), then the state goes to LOAD, not IDLE/OVER. The exception is when lives hit 0: OVER wins.
- freq in LOAD: ignored.
- Timeout and press in the same cycle: the press wins.

Reset mid-round: the round is discarded, pulses are cleared, and score/lives return to their reset values.

Test Plan (WINDOW_CYCLES=16, LIVES=3):
- Reset with btn=8'h01 held, then release and press btn[0] in IDLE -> no hit/miss, score=0, lives=3.
- freq with LED_num=8'h04 valid the next cycle; press btn[2] 5 cycles after armed rises -> hit pulse 1 cycle after the press, score=1, armed=0.
- Arm with LED_num=8'h10; press btn[3] -> miss pulse, lives=2, score unchanged. Next round: press btn[4] together with btn[5] -> miss, lives=1.
- Arm with LED_num=8'h80; no press -> miss on the 16th ARMED cycle, lives 1->0, game_over=1. Further freq and btn activity leaves score/lives unchanged and armed=0 until rst.
- Arm with LED_num=8'h02; assert freq and press btn[1] in the same cycle -> hit, score+1, state LOAD, new target captured next cycle. Repeat score increments at 8'hFF -> score stays 8'hFF.
- Arm with LED_num=8'h00 or 8'h03 -> returns to IDLE, armed never rises, no pulses. Assert rst mid-ARMED -> every output at its reset value on the next edge.
